// File: rtl/rc4_ksa_if.sv
// rtl/rc4_ksa_if.sv - key-burst input, status and S-box access port bundle for rc4_ksa
interface rc4_ksa_if;
    logic       key_valid;
    logic [7:0] key_in;
    logic       ksa_done;
    logic       busy;
    logic [5:0] key_len;
    logic [7:0] s_rd_addr;
    logic [7:0] s_rd_data;
    logic       s_wr_en;
    logic [7:0] s_wr_addr;
    logic [7:0] s_wr_data;

    modport master (
        output key_valid,
        output key_in,
        output s_rd_addr,
        output s_wr_en,
        output s_wr_addr,
        output s_wr_data,
        input  ksa_done,
        input  busy,
        input  key_len,
        input  s_rd_data
    );

    modport slave (
        input  key_valid,
        input  key_in,
        input  s_rd_addr,
        input  s_wr_en,
        input  s_wr_addr,
        input  s_wr_data,
        output ksa_done,
        output busy,
        output key_len,
        output s_rd_data
    );
endinterface

// File: rtl/rc4_ksa.sv
// rtl/rc4_ksa.sv - RC4 key-scheduling engine; define RC4_KSA_FAST_EN for one iteration per cycle
module rc4_ksa (
    input  logic       clk,
    input  logic       rst,
    rc4_ksa_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_INIT,
        ST_KSA,
        ST_DONE
    } state_t;

    state_t     state;
    logic [7:0] s_box [256];
    logic [7:0] k_mem [32];
    logic [5:0] key_len_q;
    logic [7:0] i_q;
    logic [7:0] j_q;
    logic [4:0] kidx_q;
    logic       busy_q;
    logic       done_q;

    logic [7:0] s_i;
    logic [7:0] k_k;
    logic [7:0] j_next;
    logic [4:0] kidx_next;
    logic [5:0] kidx_inc;

    assign s_i       = s_box[i_q];
    assign k_k       = k_mem[kidx_q];
    assign j_next    = j_q + s_i + k_k;
    assign kidx_inc  = {1'b0, kidx_q} + 6'd1;
    assign kidx_next = (kidx_inc == key_len_q) ? 5'd0 : kidx_inc[4:0];

`ifdef RC4_KSA_FAST_EN
    logic [7:0] s_jn;
    assign s_jn = s_box[j_next];
`else
    logic       phase_q;
    logic [7:0] s_j;
    assign s_j = s_box[j_q];
`endif

    assign bus.ksa_done  = done_q;
    assign bus.busy      = busy_q;
    assign bus.key_len   = key_len_q;
    // The S-box belongs to downstream only once scheduling has finished.
    assign bus.s_rd_data = done_q ? s_box[bus.s_rd_addr] : 8'h00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            key_len_q <= 6'd0;
            i_q       <= 8'd0;
            j_q       <= 8'd0;
            kidx_q    <= 5'd0;
`ifndef RC4_KSA_FAST_EN
            phase_q   <= 1'b0;
`endif
            for (int n = 0; n < 256; n++) begin
                s_box[n] <= 8'(n);
            end
            for (int n = 0; n < 32; n++) begin
                k_mem[n] <= 8'h00;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.key_valid) begin
                        k_mem[0]  <= bus.key_in;
                        key_len_q <= 6'd1;
                        busy_q    <= 1'b1;
                        state     <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (bus.key_valid) begin
                        // Bytes past the 32nd are accepted on the bus but discarded.
                        if (key_len_q < 6'd32) begin
                            k_mem[key_len_q[4:0]] <= bus.key_in;
                            key_len_q             <= key_len_q + 6'd1;
                        end
                    end else begin
                        state <= ST_INIT;
                    end
                end

                ST_INIT: begin
                    for (int n = 0; n < 256; n++) begin
                        s_box[n] <= 8'(n);
                    end
                    i_q    <= 8'd0;
                    j_q    <= 8'd0;
                    kidx_q <= 5'd0;
`ifndef RC4_KSA_FAST_EN
                    phase_q <= 1'b0;
`endif
                    state  <= ST_KSA;
                end

                ST_KSA: begin
`ifdef RC4_KSA_FAST_EN
                    j_q            <= j_next;
                    s_box[i_q]     <= s_jn;
                    s_box[j_next]  <= s_i;
                    i_q            <= i_q + 8'd1;
                    kidx_q         <= kidx_next;
                    if (i_q == 8'hFF) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end
`else
                    if (!phase_q) begin
                        j_q     <= j_next;
                        phase_q <= 1'b1;
                    end else begin
                        // With i==j both writes carry the same byte, so S is unchanged.
                        s_box[i_q] <= s_j;
                        s_box[j_q] <= s_i;
                        i_q        <= i_q + 8'd1;
                        kidx_q     <= kidx_next;
                        phase_q    <= 1'b0;
                        if (i_q == 8'hFF) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
`endif
                end

                ST_DONE: begin
                    if (bus.key_valid) begin
                        k_mem[0]  <= bus.key_in;
                        key_len_q <= 6'd1;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        state     <= ST_LOAD;
                    end else if (bus.s_wr_en) begin
                        s_box[bus.s_wr_addr] <= bus.s_wr_data;
                    end
                end

                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
